// File: rtl/port_allocator.sv
`default_nettype none
// ============================================================================
// Module      : port_allocator
// Description : Five-input wormhole output-port allocator. A round-robin
//               arbiter grants one input, holds it for the whole packet and
//               releases on the tail flit. A credit counter tracks the free
//               downstream slots and stalls transfers when none are left.
//               Optional idle-grant watchdog compiled in with the macro
//               ALLOC_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module port_allocator #(
    parameter int CREDIT_DEPTH   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req,
    input  logic [4:0] flit_valid,
    input  logic [4:0] flit_tail,
    input  logic       credit_in,
    output logic [4:0] grant,
    output logic [2:0] sel,
    output logic       fire,
    output logic [3:0] credit_cnt,
    output logic       timeout,
    output logic       credit_err
);

    localparam logic       c_ST_IDLE    = 1'b0;
    localparam logic       c_ST_HOLD    = 1'b1;
    localparam logic [3:0] c_CREDIT_MAX = 4'(CREDIT_DEPTH);

    // Out-of-range configurations stop elaboration.
    generate
        if (CREDIT_DEPTH < 1 || CREDIT_DEPTH > 15 ||
            TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
            $error("port_allocator: parameter out of range");
        end
    endgenerate

    logic       r_state;
    logic [4:0] r_grant;
    logic [2:0] r_sel;
    logic [2:0] r_rr_ptr;
    logic [3:0] r_credit_cnt;
    logic       r_credit_err;

    logic       w_fire;
    logic       w_tail_fire;
    logic       w_wd_expire;
    logic       w_release;
    logic       w_pick_found;
    logic [2:0] w_pick_idx;
    logic [3:0] w_sum;
    logic [2:0] w_cand;
    logic [2:0] w_next_ptr;

    // A flit moves only when the granted input has one and a slot is free.
    assign w_fire      = (|(r_grant & flit_valid)) && (r_credit_cnt != 4'd0);
    // Tail is only honoured when it actually transfers (a stalled tail holds).
    assign w_tail_fire = w_fire && (|(r_grant & flit_tail));
    assign w_release   = (r_state == c_ST_HOLD) && (w_tail_fire || w_wd_expire);
    assign w_next_ptr  = (r_sel == 3'd4) ? 3'd0 : r_sel + 3'd1;

    // Round-robin search: first requesting input at or after rr_ptr, mod 5.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = 3'd0;
        w_sum        = 4'd0;
        w_cand       = 3'd0;
        for (int i = 0; i < 5; i++) begin
            w_sum  = {1'b0, r_rr_ptr} + 4'(i);
            w_cand = (w_sum >= 4'd5) ? 3'(w_sum - 4'd5) : w_sum[2:0];
            if (!w_pick_found && req[w_cand]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_cand;
            end
        end
    end

    // Grant FSM: IDLE arbitrates, HOLD keeps the grant until tail or watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_grant  <= 5'b00000;
            r_sel    <= 3'd0;
            r_rr_ptr <= 3'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pick_found) begin
                        r_state <= c_ST_HOLD;
                        r_grant <= 5'b00001 << w_pick_idx;
                        r_sel   <= w_pick_idx;
                    end
                end
                default: begin
                    if (w_release) begin
                        r_state  <= c_ST_IDLE;
                        r_grant  <= 5'b00000;
                        r_sel    <= 3'd0;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
            endcase
        end
    end

    // Credit counter: a transfer consumes a slot, credit_in returns one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit_cnt <= c_CREDIT_MAX;
            r_credit_err <= 1'b0;
        end else begin
            case ({w_fire, credit_in})
                2'b10: r_credit_cnt <= r_credit_cnt - 4'd1;
                2'b01: begin
                    // A return with every slot already free is a protocol error.
                    if (r_credit_cnt == c_CREDIT_MAX) begin
                        r_credit_err <= 1'b1;
                    end else begin
                        r_credit_cnt <= r_credit_cnt + 4'd1;
                    end
                end
                default: r_credit_cnt <= r_credit_cnt;
            endcase
        end
    end

`ifdef ALLOC_TIMEOUT_EN
    localparam logic [7:0] c_WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_wd_cnt;
    logic       r_timeout;

    // Expiry on the cycle that would bring the idle count to TIMEOUT_CYCLES.
    assign w_wd_expire = (r_state == c_ST_HOLD) && !w_fire && (r_wd_cnt == c_WD_LAST);

    // Watchdog counts idle HOLD cycles; zero outside HOLD so entry starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt  <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_wd_expire;
            if ((r_state != c_ST_HOLD) || w_fire || w_wd_expire) begin
                r_wd_cnt <= 8'd0;
            end else begin
                r_wd_cnt <= r_wd_cnt + 8'd1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_wd_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

    assign grant      = r_grant;
    assign sel        = r_sel;
    assign fire       = w_fire;
    assign credit_cnt = r_credit_cnt;
    assign credit_err = r_credit_err;

endmodule
`default_nettype wire
